// File: rtl/stack_cpu_pkg.sv
// Shared opcode map, FSM state encoding and fault codes for the stack-machine controller.
package stack_cpu_pkg;

  localparam int unsigned OP_ADD    = 32'h00;
  localparam int unsigned OP_SUB    = 32'h01;
  localparam int unsigned OP_MUL    = 32'h02;
  localparam int unsigned OP_DIV    = 32'h03;
  localparam int unsigned OP_AND    = 32'h04;
  localparam int unsigned OP_NAND   = 32'h05;
  localparam int unsigned OP_OR     = 32'h06;
  localparam int unsigned OP_XOR    = 32'h07;
  localparam int unsigned OP_CMP    = 32'h08;
  localparam int unsigned OP_NOT    = 32'h09;
  localparam int unsigned OP_PUSH   = 32'h0A;
  localparam int unsigned OP_PUSH_I = 32'h0B;
  localparam int unsigned OP_PUSH_T = 32'h0C;
  localparam int unsigned OP_POP    = 32'h0D;
  localparam int unsigned OP_GOTO   = 32'h0E;
  localparam int unsigned OP_IF_EQ  = 32'h0F;
  localparam int unsigned OP_IF_GT  = 32'h10;
  localparam int unsigned OP_IF_LT  = 32'h11;
  localparam int unsigned OP_IF_GE  = 32'h12;
  localparam int unsigned OP_IF_LE  = 32'h13;
  localparam int unsigned OP_CALL   = 32'h14;
  localparam int unsigned OP_RET    = 32'h15;
  localparam int unsigned OP_HALT   = 32'h16;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_POP_B, S_POP_A, S_EXEC, S_MEM_RD,
    S_MEM_WAIT, S_PUSH, S_MEM_WR, S_NEXT, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_OPND_UNDER = 3'd1;
  localparam logic [2:0] FC_OPND_OVER  = 3'd2;
  localparam logic [2:0] FC_ILLEGAL    = 3'd3;
  localparam logic [2:0] FC_RET_OVER   = 3'd4;
  localparam logic [2:0] FC_RET_UNDER  = 3'd5;

  // Conditional-branch predicate from the CMP flags.
  function automatic logic branch_taken(input int unsigned op, input logic eq, input logic lt);
    case (op)
      OP_IF_EQ: return eq;
      OP_IF_GT: return !eq && !lt;
      OP_IF_LT: return lt;
      OP_IF_GE: return !lt;
      OP_IF_LE: return eq || lt;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Small LIFO of return addresses for CALL/RET; the caller guards push/pop with full/empty.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = PTR_W'(cnt);
  assign rd_idx = PTR_W'(cnt - CNT_W'(1));
  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt <= '0;
    else if (push && !full)   cnt <= cnt + CNT_W'(1);
    else if (pop && !empty)   cnt <= cnt - CNT_W'(1);
  end

  // Entries are only meaningful below cnt, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/stack_cpu_ctrl.sv
// Stack-machine control FSM: fetch/decode, operand-stack, data-memory and ALU sequencing,
// branches and CALL/RET through an internal return-address stack, with latched faults.
module stack_cpu_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned OPC_W     = 5,
  parameter int unsigned RET_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_en,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [OPC_W+ADDR_W-1:0] imem_data,
  output logic                    dmem_en,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic [DATA_W-1:0]       dmem_rdata,
  output logic                    stk_push,
  output logic                    stk_pop,
  output logic [DATA_W-1:0]       stk_din,
  input  logic [DATA_W-1:0]       stk_top,
  input  logic                    stk_full,
  input  logic                    stk_empty,
  output logic [OPC_W-1:0]        alu_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_lt,
  output logic                    halted,
  output logic                    fault,
  output logic [2:0]              fault_code
);
  localparam int unsigned INSN_W = OPC_W + ADDR_W;

  state_t            state, state_n;
  logic              live;
  logic [ADDR_W-1:0] ip, ip_n, opnd, opnd_n, ip_inc;
  logic [OPC_W-1:0]  ir, ir_n;
  logic [DATA_W-1:0] a, a_n, b, b_n, r, r_n, t1, t1_n;
  logic              eq, eq_n, lt, lt_n;
  logic [2:0]        fcode, fcode_n;
  logic [OPC_W-1:0]  dec_opc;
  logic [ADDR_W-1:0] dec_opnd;
  logic [31:0]       dec_op, ir_op;
  logic              rs_push, rs_pop, rs_full, rs_empty;
  logic [ADDR_W-1:0] rs_top;

  assign dec_opc  = imem_data[INSN_W-1 -: OPC_W];
  assign dec_opnd = imem_data[ADDR_W-1:0];
  assign dec_op   = 32'(dec_opc);
  assign ir_op    = 32'(ir);
  assign ip_inc   = ip + ADDR_W'(1);

  ret_addr_stack #(.DEPTH(RET_DEPTH), .W(ADDR_W)) u_ret (
    .clk   (clk),
    .reset (reset),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (ip_inc),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty)
  );

  // live holds the FSM in FETCH for one cycle after reset so every strobe reads 0 under reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      live  <= 1'b0;
      ip    <= '0;
      ir    <= '0;
      opnd  <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      t1    <= '0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      fcode <= FC_NONE;
    end else begin
      state <= state_n;
      live  <= 1'b1;
      ip    <= ip_n;
      ir    <= ir_n;
      opnd  <= opnd_n;
      a     <= a_n;
      b     <= b_n;
      r     <= r_n;
      t1    <= t1_n;
      eq    <= eq_n;
      lt    <= lt_n;
      fcode <= fcode_n;
    end
  end

  always_comb begin
    state_n    = state;
    ip_n       = ip;
    ir_n       = ir;
    opnd_n     = opnd;
    a_n        = a;
    b_n        = b;
    r_n        = r;
    t1_n       = t1;
    eq_n       = eq;
    lt_n       = lt;
    fcode_n    = fcode;
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
    imem_en    = 1'b0;
    imem_addr  = ip;
    dmem_en    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = opnd;
    dmem_wdata = '0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_din    = '0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    halted     = 1'b0;
    fault      = 1'b0;
    fault_code = '0;

    case (state)
      S_FETCH: begin
        imem_en = live;
        if (live) state_n = S_DECODE;
      end
      S_DECODE: begin
        ir_n   = dec_opc;
        opnd_n = dec_opnd;
        case (dec_op)
          OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_NAND, OP_OR, OP_XOR,
          OP_CMP, OP_NOT, OP_POP:                 state_n = S_POP_B;
          OP_PUSH:                                state_n = S_MEM_RD;
          OP_PUSH_I: begin
            r_n     = DATA_W'(dec_opnd);
            state_n = S_PUSH;
          end
          OP_PUSH_T: begin
            r_n     = t1;
            state_n = S_PUSH;
          end
          OP_GOTO, OP_IF_EQ, OP_IF_GT, OP_IF_LT, OP_IF_GE, OP_IF_LE,
          OP_CALL, OP_RET:                        state_n = S_NEXT;
          OP_HALT:                                state_n = S_HALT;
          default: begin
            fcode_n = FC_ILLEGAL;
            state_n = S_FAULT;
          end
        endcase
      end
      S_POP_B: begin
        if (stk_empty) begin
          fcode_n = FC_OPND_UNDER;
          state_n = S_FAULT;
        end else begin
          stk_pop = 1'b1;
          b_n     = stk_top;
          if (ir_op == OP_NOT) begin
            a_n     = stk_top;
            b_n     = '0;
            state_n = S_EXEC;
          end else if (ir_op == OP_POP) begin
            state_n = S_MEM_WR;
          end else begin
            state_n = S_POP_A;
          end
        end
      end
      S_POP_A: begin
        if (stk_empty) begin
          fcode_n = FC_OPND_UNDER;
          state_n = S_FAULT;
        end else begin
          stk_pop = 1'b1;
          a_n     = stk_top;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = ir;
        alu_a  = a;
        alu_b  = b;
        if (ir_op == OP_CMP) begin
          eq_n    = alu_zero;
          lt_n    = alu_lt;
          state_n = S_NEXT;
        end else begin
          r_n     = alu_result;
          state_n = S_PUSH;
        end
      end
      S_MEM_RD: begin
        dmem_en = 1'b1;
        state_n = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        r_n     = dmem_rdata;
        state_n = S_PUSH;
      end
      S_PUSH: begin
        if (stk_full) begin
          fcode_n = FC_OPND_OVER;
          state_n = S_FAULT;
        end else begin
          stk_push = 1'b1;
          stk_din  = r;
          state_n  = S_NEXT;
        end
      end
      S_MEM_WR: begin
        dmem_en    = 1'b1;
        dmem_we    = 1'b1;
        dmem_wdata = b;
        t1_n       = b;
        state_n    = S_NEXT;
      end
      S_NEXT: begin
        state_n = S_FETCH;
        ip_n    = ip_inc;
        case (ir_op)
          OP_GOTO: ip_n = opnd;
          OP_IF_EQ, OP_IF_GT, OP_IF_LT, OP_IF_GE, OP_IF_LE:
            if (branch_taken(ir_op, eq, lt)) ip_n = opnd;
          OP_CALL: begin
            if (rs_full) begin
              ip_n    = ip;
              fcode_n = FC_RET_OVER;
              state_n = S_FAULT;
            end else begin
              rs_push = 1'b1;
              ip_n    = opnd;
            end
          end
          OP_RET: begin
            if (rs_empty) begin
              ip_n    = ip;
              fcode_n = FC_RET_UNDER;
              state_n = S_FAULT;
            end else begin
              rs_pop = 1'b1;
              ip_n   = rs_top;
            end
          end
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: begin
        fault      = 1'b1;
        fault_code = fcode;
      end
      default: state_n = S_FETCH;
    endcase
  end

endmodule
